// File: rtl/mem_capture_ctrl.sv
// mem_capture_ctrl: unpacks FIFO words into sample-memory writes until DEPTH samples are captured (optional trigger gate: CAPTURE_TRIG_EN)
module mem_capture_ctrl #(
  parameter int SAMPLE_W = 24,
  parameter int LANES    = 32,
  parameter int DEPTH    = 3750,
  parameter int ADDR_W   = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [SAMPLE_W*LANES-1:0] fifo_data,
  input  logic [5:0]                num_samples,
  input  logic                      fifo_valid,
  output logic                      fifo_ready,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [SAMPLE_W-1:0]       mem_wdata,
  output logic                      busy,
  output logic                      acquired,
`ifdef CAPTURE_TRIG_EN
  input  logic [SAMPLE_W-1:0]       trig_level,
  output logic                      triggered,
`endif
  output logic [ADDR_W-1:0]         wr_count
);
  localparam int LANE_W = $clog2(LANES);
  localparam logic [5:0] LANES_N = 6'(LANES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, WAIT_WORD, UNPACK, DONE} state_t;
  state_t state_q, state_d;
  logic [SAMPLE_W*LANES-1:0] word_q, word_d;
  logic [5:0] n_q, n_d, n_in;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ADDR_W-1:0] wr_q, wr_d, wr_inc;
  logic [SAMPLE_W-1:0] lane_data [LANES];
  logic [SAMPLE_W-1:0] sample;
  logic hit, we, last_lane;
`ifdef CAPTURE_TRIG_EN
  logic trig_q, trig_d;
  assign hit = trig_q || ($signed(sample) >= $signed(trig_level));
  assign triggered = trig_q;
`else
  assign hit = 1'b1;
`endif
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_data[k] = word_q[SAMPLE_W*(LANES-k)-1 -: SAMPLE_W];
  end
  assign sample     = lane_data[lane_q];
  assign n_in       = (num_samples > LANES_N) ? LANES_N : num_samples;
  assign we         = (state_q == UNPACK) && hit;
  assign wr_inc     = wr_q + ADDR_W'(1);
  assign last_lane  = (6'(lane_q) + 6'd1) == n_q;
  assign fifo_ready = state_q == WAIT_WORD;
  assign busy       = (state_q == WAIT_WORD) || (state_q == UNPACK);
  assign acquired   = state_q == DONE;
  assign mem_we     = we;
  assign mem_addr   = wr_q;
  assign mem_wdata  = sample;
  assign wr_count   = wr_q;
  // state, word buffer and pointers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      n_q     <= '0;
      lane_q  <= '0;
      wr_q    <= '0;
`ifdef CAPTURE_TRIG_EN
      trig_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      n_q     <= n_d;
      lane_q  <= lane_d;
      wr_q    <= wr_d;
`ifdef CAPTURE_TRIG_EN
      trig_q  <= trig_d;
`endif
    end
  end
  // next state; a write in progress is still counted when abort lands on it
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    n_d     = n_q;
    lane_d  = lane_q;
    wr_d    = we ? wr_inc : wr_q;
`ifdef CAPTURE_TRIG_EN
    trig_d  = trig_q;
`endif
    if (abort) begin
      state_d = IDLE;
`ifdef CAPTURE_TRIG_EN
      trig_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_d = WAIT_WORD;
          wr_d    = '0;
          lane_d  = '0;
`ifdef CAPTURE_TRIG_EN
          trig_d  = 1'b0;
`endif
        end
        WAIT_WORD: if (fifo_valid) begin
          word_d  = fifo_data;
          n_d     = n_in;
          lane_d  = '0;
          state_d = (n_in == 6'd0) ? WAIT_WORD : UNPACK;
        end
        UNPACK: begin
          lane_d  = lane_q + 1'b1;
`ifdef CAPTURE_TRIG_EN
          trig_d  = hit;
`endif
          state_d = (we && wr_q == LAST_ADDR) ? DONE : last_lane ? WAIT_WORD : UNPACK;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule
